// File: rtl/booth_multiplier_param.sv
// Sequential radix-2 Booth multiplier: serial operand load, one Booth step per clock,
// 2*WIDTH product returned over the WIDTH-bit bus as a high beat then a low beat.
module booth_multiplier_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             out_hi,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [2:0] {IDLE, LOAD_Q, STEP, OUT_HI, OUT_LO} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   m_q, m_d, a_q, a_d, q_q, q_d;
    logic             qm1_q, qm1_d, sgn_q, sgn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, hi_q, hi_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic [WIDTH:0]     a_sum;
    logic [2*WIDTH+2:0] shr;

    // One Booth step: add/sub on the WIDTH+1 bit accumulator, then arithmetic shift of {A,Q,q-1}.
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b10:   a_sum = a_q - m_q;
            2'b01:   a_sum = a_q + m_q;
            default: a_sum = a_q;
        endcase
        shr = {a_sum[WIDTH], a_sum, q_q};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {signed_mode & data_in[WIDTH-1], data_in};
                    sgn_d   = signed_mode;
                    state_d = LOAD_Q;
                end
            end
            LOAD_Q: begin
                q_d     = {sgn_q & data_in[WIDTH-1], data_in};
                a_d     = '0;
                qm1_d   = 1'b0;
                cnt_d   = CNT_W'(WIDTH + 1);
                state_d = STEP;
            end
            STEP: begin
                a_d   = shr[2*WIDTH+2:WIDTH+2];
                q_d   = shr[WIDTH+1:1];
                qm1_d = shr[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = OUT_HI;
            end
            OUT_HI:  state_d = OUT_LO;
            OUT_LO:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so each beat lines up with its state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == OUT_HI) || (state_d == OUT_LO);
        hi_d   = (state_d == OUT_HI);
        case (state_d)
            OUT_HI:  dout_d = {a_d[WIDTH-2:0], q_d[WIDTH]};
            OUT_LO:  dout_d = q_d[WIDTH-1:0];
            default: dout_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            dout_q  <= dout_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out_hi   = hi_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Scoreboard bench for booth_multiplier_param at WIDTH=8 and WIDTH=5.
module tb_booth_multiplier_param;

    localparam int W8 = 8;
    localparam int W5 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start8 = 0, sgn8 = 0, busy8, done8, hi8;
    logic [W8-1:0] din8 = '0, dout8;
    logic          start5 = 0, sgn5 = 0, busy5, done5, hi5;
    logic [W5-1:0] din5 = '0, dout5;

    booth_multiplier_param #(.WIDTH(W8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sgn8), .data_in(din8),
        .busy(busy8), .done(done8), .out_hi(hi8), .data_out(dout8));

    booth_multiplier_param #(.WIDTH(W5)) u5 (
        .clk(clk), .rst(rst), .start(start5), .signed_mode(sgn5), .data_in(din5),
        .busy(busy5), .done(done5), .out_hi(hi5), .data_out(dout5));

    typedef struct {
        logic [31:0] prod;
        int          cyc_hi;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];
    int   last8 = -1000, last5 = -1000;
    int   cyc = 0;
    int   nvec = 0, nbad = 0;
    bit   mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer multiply of the interpreted operand values.
    function automatic logic [31:0] ref_mul(int w, logic [15:0] m, logic [15:0] q, bit s);
        longint sm, sq, p;
        sm = longint'(m);
        sq = longint'(q);
        if (s && m[w-1]) sm = sm - (longint'(1) << w);
        if (s && q[w-1]) sq = sq - (longint'(1) << w);
        p = sm * sq;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(logic [7:0] m, logic [7:0] q, bit s);
        exp_t e;
        start8 = 1; din8 = m; sgn8 = s;
        if (cyc > last8 + W8 + 4) begin
            e.prod = ref_mul(W8, {8'h0, m}, {8'h0, q}, s);
            e.cyc_hi = cyc + W8 + 3;
            q8.push_back(e);
            last8 = cyc;
        end
        tick();
        start8 = 0; din8 = q;
        tick();
        din8 = 8'($urandom); sgn8 = 1'($urandom);
    endtask

    task automatic issue5(logic [4:0] m, logic [4:0] q, bit s);
        exp_t e;
        start5 = 1; din5 = m; sgn5 = s;
        if (cyc > last5 + W5 + 4) begin
            e.prod = ref_mul(W5, {11'h0, m}, {11'h0, q}, s);
            e.cyc_hi = cyc + W5 + 3;
            q5.push_back(e);
            last5 = cyc;
        end
        tick();
        start5 = 0; din5 = q;
        tick();
        din5 = 5'($urandom); sgn5 = 1'($urandom);
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("busy8", 32'(busy8), 32'(cyc >= last8 + 1 && cyc <= last8 + W8 + 4));
        if (done8) begin
            if (q8.size() == 0) chk("spurious_done8", 32'(done8), 32'd0);
            else if (hi8) begin
                chk("hi_cycle8", cyc, q8[0].cyc_hi);
                chk("hi_data8", 32'(dout8), 32'(q8[0].prod[15:8]));
            end else begin
                chk("lo_cycle8", cyc, q8[0].cyc_hi + 1);
                chk("lo_data8", 32'(dout8), 32'(q8[0].prod[7:0]));
                void'(q8.pop_front());
            end
        end else begin
            chk("idle_out8", {23'h0, hi8, dout8}, 32'd0);
            if (q8.size() > 0 && cyc > q8[0].cyc_hi + 1) begin
                chk("timeout8", cyc, q8[0].cyc_hi + 1);
                void'(q8.pop_front());
            end
        end
    end

    always @(negedge clk) if (mon_en) begin
        chk("busy5", 32'(busy5), 32'(cyc >= last5 + 1 && cyc <= last5 + W5 + 4));
        if (done5) begin
            if (q5.size() == 0) chk("spurious_done5", 32'(done5), 32'd0);
            else if (hi5) begin
                chk("hi_cycle5", cyc, q5[0].cyc_hi);
                chk("hi_data5", 32'(dout5), 32'(q5[0].prod[9:5]));
            end else begin
                chk("lo_cycle5", cyc, q5[0].cyc_hi + 1);
                chk("lo_data5", 32'(dout5), 32'(q5[0].prod[4:0]));
                void'(q5.pop_front());
            end
        end else begin
            chk("idle_out5", {26'h0, hi5, dout5}, 32'd0);
            if (q5.size() > 0 && cyc > q5[0].cyc_hi + 1) begin
                chk("timeout5", cyc, q5[0].cyc_hi + 1);
                void'(q5.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
        tick();

        issue8(8'hFD, 8'h05, 1); repeat (W8 + 3) tick();
        issue8(8'hFF, 8'hFF, 0); repeat (W8 + 3) tick();
        issue8(8'hFF, 8'hFF, 1); repeat (W8 + 3) tick();
        issue8(8'h80, 8'h80, 1); repeat (W8 + 3) tick();
        issue8(8'h00, 8'h7F, 1); repeat (W8 + 3) tick();
        issue5(5'h0F, 5'h10, 1); repeat (W5 + 3) tick();
        issue5(5'h10, 5'h10, 1); repeat (W5 + 3) tick();
        issue5(5'h1F, 5'h1F, 0); repeat (W5 + 3) tick();

        // New request while stepping must be ignored.
        issue8(8'h12, 8'h34, 1);
        repeat (3) tick();
        issue8(8'h56, 8'h78, 0);
        repeat (W8 + 3) tick();

        // Reset in the middle of the Booth steps aborts the operation.
        issue8(8'h9A, 8'hBC, 0);
        repeat (4) tick();
        rst = 1;
        tick();
        q8.delete(); q5.delete();
        last8 = -1000; last5 = -1000;
        rst = 0;
        tick();
        issue8(8'h9A, 8'hBC, 0); repeat (W8 + 3) tick();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                issue8(8'($urandom), 8'($urandom), 1'($urandom));
                repeat ($urandom_range(W8 + 1, W8 + 5)) tick();
            end else begin
                issue5(5'($urandom), 5'($urandom), 1'($urandom));
                repeat ($urandom_range(W5 + 1, W5 + 5)) tick();
            end
        end

        repeat (20) tick();
        if (q8.size() != 0) chk("drain8", q8.size(), 0);
        if (q5.size() != 0) chk("drain5", q5.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
